// File: rtl/serial_paralelo_rx.sv
// Receive-side lane deserializer: shifts in MSB-first serial bits, locks byte alignment
// on a run of COM symbols, then forwards each non-COM byte with a valid strobe.
module serial_paralelo_rx #(
    parameter logic [7:0]  COM      = 8'hBC,
    parameter int unsigned COM_LOCK = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {StSearch, StAlign, StActive} state_e;

    localparam logic [3:0] LockCnt = 4'(COM_LOCK);

    state_e     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bc_q, bc_d;
    logic [3:0] comcnt_q, comcnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_out_q, valid_out_d;
    logic       active_q, active_d;

    logic [7:0] window;
    logic       is_com;
    logic       byte_done;
    logic [3:0] comcnt_inc;

    always_comb begin
        window     = {sr_q[6:0], data_in};
        is_com     = (window == COM);
        // SEARCH hunts every bit; once aligned, bytes end on a fixed 8-bit grid.
        byte_done  = (state_q == StSearch) ? is_com : (bc_q == 3'd7);
        comcnt_inc = comcnt_q + 4'd1;

        sr_d        = window;
        bc_d        = byte_done ? 3'd0 : bc_q + 3'd1;
        state_d     = state_q;
        comcnt_d    = comcnt_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        active_d    = active_q;

        unique case (state_q)
            StSearch: begin
                if (is_com) begin
                    comcnt_d = 4'd1;
                    if (LockCnt == 4'd1) begin
                        state_d  = StActive;
                        active_d = 1'b1;
                    end else begin
                        state_d = StAlign;
                    end
                end
            end
            StAlign: begin
                if (byte_done) begin
                    if (is_com) begin
                        comcnt_d = comcnt_inc;
                        if (comcnt_inc == LockCnt) begin
                            state_d  = StActive;
                            active_d = 1'b1;
                        end
                    end else begin
                        comcnt_d = 4'd0;
                        state_d  = StSearch;
                    end
                end
            end
            StActive: begin
                if (byte_done) begin
                    data_out_d  = window;
                    valid_out_d = !is_com;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q     <= StSearch;
            sr_q        <= 8'h00;
            bc_q        <= 3'd0;
            comcnt_q    <= 4'd0;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bc_q        <= bc_d;
            comcnt_q    <= comcnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            active_q    <= active_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: bit-level driver with a queue of expected output
// snapshots keyed by bit index since the last reset release.
module tb_serial_paralelo_rx;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    serial_paralelo_rx dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] d;
        logic       v;
        logic       a;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic [7:0] d;
        logic       v;
    } vec_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    nbit;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [7:0] d, input logic v, input logic a);
        n_checks++;
        if ({data_out, valid_out, active} !== {d, v, a}) begin
            n_fail++;
            $display("FAIL %s @bit %0d: got data_out=%h valid_out=%b active=%b, want %h %b %b",
                     name, nbit, data_out, valid_out, active, d, v, a);
        end
    endtask

    task automatic push_exp(input int at, input logic [7:0] d, input logic v, input logic a,
                            input string name);
        exp_t e;
        e.at = at; e.d = d; e.v = v; e.a = a;
        sb_q.push_back(e);
        nm_q.push_back(name);
    endtask

    task automatic drive_bit(input logic b);
        exp_t  e;
        string n;
        data_in = b;
        @(posedge clk);
        #1;
        nbit++;
        while (sb_q.size() > 0 && sb_q[0].at <= nbit) begin
            e = sb_q.pop_front();
            n = nm_q.pop_front();
            check(n, e.d, e.v, e.a);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) drive_bit(b[i]);
    endtask

    task automatic sb_flush();
        string n;
        while (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
            n = nm_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation never reached, got none, want a check at bit", n);
        end
    endtask

    task automatic do_reset(input int n);
        reset_L = 1'b0;
        for (int i = 0; i < n; i++) begin
            data_in = 1'($urandom);
            @(posedge clk);
            #1;
            check("reset", 8'h00, 1'b0, 1'b0);
        end
        reset_L = 1'b1;
        nbit = 0;
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{b: 8'h55, d: 8'h55, v: 1'b1};
        tbl[1] = '{b: 8'hA3, d: 8'hA3, v: 1'b1};
        tbl[2] = '{b: 8'hBC, d: 8'hBC, v: 1'b0};
        tbl[3] = '{b: 8'h0F, d: 8'h0F, v: 1'b1};

        // Reset, then an all-zero stream must never leave SEARCH.
        do_reset(3);
        for (int i = 1; i <= 40; i++) push_exp(i, 8'h00, 1'b0, 1'b0, "zeros_idle");
        for (int i = 0; i < 40; i++) drive_bit(1'b0);
        sb_flush();

        // Lock on 4 COMs, then table-driven forwarding.
        do_reset(2);
        push_exp(8, 8'h00, 1'b0, 1'b0, "lock_first_com");
        push_exp(31, 8'h00, 1'b0, 1'b0, "lock_pre");
        push_exp(32, 8'h00, 1'b0, 1'b1, "lock_rise");
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        for (int i = 33; i <= 39; i++) push_exp(i, 8'h00, 1'b0, 1'b1, "lock_hold");
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++)
                push_exp(nbit + 8 + j, tbl[k].d, tbl[k].v, 1'b1, $sformatf("fwd%0d", k));
            send_byte(tbl[k].b);
        end
        push_exp(nbit + 8, 8'h00, 1'b1, 1'b1, "fwd_zero");
        send_byte(8'h00);
        sb_flush();

        // Three garbage bits shift the byte grid.
        do_reset(2);
        push_exp(34, 8'h00, 1'b0, 1'b0, "offs_pre");
        push_exp(35, 8'h00, 1'b0, 1'b1, "offs_lock");
        push_exp(42, 8'h00, 1'b0, 1'b1, "offs_hold");
        push_exp(43, 8'h12, 1'b1, 1'b1, "offs_data");
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        send_byte(8'h12);
        sb_flush();

        // Broken COM run drops back to SEARCH; relock needs a full new run.
        do_reset(2);
        push_exp(24, 8'h00, 1'b0, 1'b0, "broken_3com");
        push_exp(32, 8'h00, 1'b0, 1'b0, "broken_drop");
        push_exp(56, 8'h00, 1'b0, 1'b0, "broken_relock_pre");
        push_exp(63, 8'h00, 1'b0, 1'b0, "broken_relock_pre2");
        push_exp(64, 8'h00, 1'b0, 1'b1, "broken_relock");
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        sb_flush();

        // Reset while data is flowing clears the lock.
        do_reset(2);
        push_exp(32, 8'h00, 1'b0, 1'b1, "mid_lock");
        push_exp(40, 8'h77, 1'b1, 1'b1, "mid_data");
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        send_byte(8'h77);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
        sb_flush();
        do_reset(1);
        push_exp(24, 8'h00, 1'b0, 1'b0, "mid_relock_3com");
        push_exp(31, 8'h00, 1'b0, 1'b0, "mid_relock_pre");
        push_exp(32, 8'h00, 1'b0, 1'b1, "mid_relock");
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        sb_flush();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
- Receive-side deserializer of the PCIe PHY lane. It sits directly upstream of the 1x2 8-bit demux and feeds its In0/validIn inputs.
- Converts the serial bit stream into 8-bit bytes and locks byte alignment on the COM symbol.
- Asserts `active` after a run of consecutive aligned COMs.
- Forwards only non-COM bytes as valid data.

Parameters:
- COM, 8'hBC, alignment/idle symbol.
- COM_LOCK, 4, consecutive aligned COMs required to enter ACTIVE (range 1..15).

Ports:
- clk  input  1  serial bit clock; all logic on its rising edge.
- reset_L  input  1  synchronous reset, active-low.
- data_in  input  1  serial data, MSB of each byte first.
- data_out  output  8  deserialized byte; feeds demux In0.
- valid_out  output  1  data_out holds a non-COM byte received in ACTIVE; feeds demux validIn.
- active  output  1  lane aligned and locked.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk. Reset is synchronous and active-low (reset_L).
  - reset_L=0 at an edge sets: sr=0, bc=0, comcnt=0, state=SEARCH, data_out=8'h00, valid_out=0, active=0.
  - Reset mid-operation behaves identically; there is no memory of the previous lock.
- Datapath:
  - sr[7:0] shifts every edge: window = {sr[6:0], data_in}, and sr <= window.
  - bc is a 3-bit bit counter.
  - byte_done at an edge = (state==SEARCH && window==COM) || (state!=SEARCH && bc==7).
  - At byte_done, bc <= 0; otherwise bc <= bc+1, wrapping 7->0.
  - Consequence: after lock, exactly 8 edges separate successive byte_done events.
- State machine (state, comcnt updated only at byte_done unless stated):
  - SEARCH: the window is compared every edge.
    - window==COM: comcnt<=1, bc<=0. Go to ALIGN, or go directly to ACTIVE if COM_LOCK==1.
    - Any other window: stay in SEARCH; bc free-runs and is ignored.
  - ALIGN:
    - At byte_done with window==COM: comcnt<=comcnt+1. When comcnt+1==COM_LOCK, go to ACTIVE and set active<=1 at that same edge.
    - At byte_done with window!=COM: comcnt<=0, go to SEARCH. The same window is not re-tested for COM at that edge.
  - ACTIVE:
    - At byte_done with window!=COM: data_out<=window, valid_out<=1.
    - At byte_done with window==COM: data_out<=window, valid_out<=0.
    - data_out and valid_out hold for the 8 edges until the next byte_done.
    - active stays 1 until reset; there is no loss-of-lock detection.
- Outputs outside ACTIVE: data_out and valid_out are not updated and stay at their reset values.
- Latency: the last bit of a byte sampled at edge N appears on data_out/valid_out right after edge N (registered at the same edge that consumes the bit).
- Boundary cases:
  - A COM pattern straddling two byte slots in ALIGN/ACTIVE is not detected; alignment never shifts after SEARCH.
  - Leading garbage bits before the first COM at any bit offset are tolerated.
  - An all-zero or all-one stream keeps the block in SEARCH indefinitely.

Test Plan:
- Reset check: reset_L=0 for 3 edges with random data_in. Required: data_out=8'h00, valid_out=0, active=0. Then release with all-zero input for 40 edges; block stays in SEARCH and all outputs are unchanged.
- Lock: send 4x 8'hBC MSB-first from edge 0. Required: active rises at the edge consuming bit 32; valid_out stays 0.
- Data forwarding after lock: follow with 8'h55, 8'hA3, 8'hBC, 8'h0F.
  - data_out=8'h55 with valid_out=1 for 8 edges, then 8'hA3 with valid_out=1.
  - Then 8'hBC with valid_out=0.
  - Then 8'h0F with valid_out=1.
- Offset alignment: 3 garbage bits 101, then 4x BC, then 8'h12. Required: active after bit 35; data_out=8'h12 with valid_out=1 after bit 43.
- Broken run: 3x BC, 8'h00, then 4x BC. Required:
  - Return to SEARCH at bit 32; active stays 0 through bit 32.
  - Relock with active=1 at bit 64.
- Reset mid-operation: after lock with data 8'h77 flowing, pull reset_L=0 for 1 edge. Required: all outputs return to reset values at that edge; 4 further BC bytes are needed to reassert active.
